// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding and idle byte
package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } spi_state_t;

  // Also driven by the SPI master controller when it has nothing to send.
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_tx_fifo.sv
// rtl/spi_tx_fifo.sv - byte FIFO feeding the SPI responder transmit shifter
module spi_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_pop;
  logic        do_push;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // A pop frees the head slot this cycle, so a push while full still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 target with oversampled pins, RX holding register and TX FIFO
module spi_responder
  import spi_pkg::*;
#(
  parameter int         TX_DEPTH  = 4,
  parameter logic [7:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_din,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic [7:0] rx_dout,
  output logic       rx_avail,
  input  logic       rx_rd,
  output logic       rx_overrun,
  output logic       tx_underrun,
  output logic       busy
);

  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;

  spi_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_dout_q, rx_dout_d;
  logic       rx_avail_q, rx_avail_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       tx_underrun_q, tx_underrun_d;

  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_empty;

  spi_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst_n  (Rst),
    .push_i (tx_wr),
    .din_i  (tx_din),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .full_o (tx_full),
    .empty_o(fifo_empty)
  );

  // Stage [1] is the synchronized level, stage [2] its one-cycle-old copy.
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_dout_d     = rx_dout_q;
    rx_avail_d    = rx_avail_q;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = 1'b0;
    fifo_pop      = 1'b0;

    if (rx_rd) begin
      rx_avail_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = 3'd0;
        if (cs_fall) state_d = S_LOAD;
      end
      S_LOAD: begin
        fifo_pop      = ~fifo_empty;
        tx_shift_d    = fifo_empty ? IDLE_BYTE : fifo_head;
        tx_underrun_d = fifo_empty;
        state_d       = S_SHIFT;
      end
      S_SHIFT: begin
        if (sck_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_dout_d  = {rx_shift_q[6:0], mosi_q[1]};
            rx_avail_d = 1'b1;
            if (rx_avail_q && !rx_rd) rx_overrun_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
          else                   state_d    = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Deselect abandons any partial byte and any loaded-but-unsent TX byte.
    if (cs_rise) begin
      state_d       = S_IDLE;
      bit_cnt_d     = 3'd0;
      fifo_pop      = 1'b0;
      tx_underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      sck_q         <= 3'b000;
      cs_q          <= 3'b111;
      mosi_q        <= 2'b00;
      state_q       <= S_IDLE;
      bit_cnt_q     <= 3'd0;
      tx_shift_q    <= 8'h00;
      rx_shift_q    <= 8'h00;
      rx_dout_q     <= 8'h00;
      rx_avail_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sck_q         <= {sck_q[1:0], spi_sck};
      cs_q          <= {cs_q[1:0], spi_cs};
      mosi_q        <= {mosi_q[0], spi_mosi};
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_dout_q     <= rx_dout_d;
      rx_avail_q    <= rx_avail_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign spi_miso    = (state_q == S_SHIFT) ? tx_shift_q[7] : 1'b1;
  assign tx_empty    = fifo_empty;
  assign rx_dout     = rx_dout_q;
  assign rx_avail    = rx_avail_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = ~cs_q[1];

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - scoreboard bench for spi_responder
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       Rst = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] tx_din = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_full, tx_empty;
  logic [7:0] rx_dout;
  logic       rx_avail;
  logic       rx_rd = 1'b0;
  logic       rx_overrun, tx_underrun, busy;

  int checks = 0;
  int errors = 0;
  int urun_cycles = 0;

  logic [7:0] exp_miso[$];
  logic [7:0] exp_rx[$];

  spi_responder #(.TX_DEPTH(4), .IDLE_BYTE(8'hFF)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .spi_sck    (spi_sck),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .tx_din     (tx_din),
    .tx_wr      (tx_wr),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .rx_dout    (rx_dout),
    .rx_avail   (rx_avail),
    .rx_rd      (rx_rd),
    .rx_overrun (rx_overrun),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_underrun) urun_cycles++;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [7:0] b);
    tx_din = b;
    tx_wr  = 1'b1;
    @(posedge clk); #1;
    tx_wr  = 1'b0;
    if (exp_miso.size() < 4) exp_miso.push_back(b);
  endtask

  function automatic logic [7:0] next_miso();
    if (exp_miso.size() == 0) return 8'hFF;
    return exp_miso.pop_front();
  endfunction

  task automatic xfer(input logic [7:0] mo, input bit last, input bit rd_done,
                      output logic [7:0] mi);
    exp_rx.push_back(mo);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      repeat (6) @(posedge clk); #1;
      mi[i] = spi_miso;
      spi_sck = 1'b1;
      if (i == 0 && rd_done) begin
        repeat (2) @(posedge clk); #1;
        rx_rd = 1'b1;
        @(posedge clk); #1;
        rx_rd = 1'b0;
        repeat (3) @(posedge clk); #1;
      end else begin
        repeat (6) @(posedge clk); #1;
      end
      spi_sck = 1'b0;
      if (i == 0 && last) spi_cs = 1'b1;
    end
  endtask

  task automatic sck_bits(input logic [7:0] mo, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = mo[7-i];
      repeat (6) @(posedge clk); #1;
      spi_sck = 1'b1;
      repeat (6) @(posedge clk); #1;
      spi_sck = 1'b0;
    end
  endtask

  task automatic wait_avail();
    int k;
    for (k = 0; k < 20 && !rx_avail; k++) @(posedge clk);
    #1;
  endtask

  task automatic select();
    spi_cs = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++; if (spi_miso !== 1'b1)   begin errors++; $display("FAIL reset_miso: got %b expected 1", spi_miso); end
    checks++; if (rx_dout !== 8'h00)   begin errors++; $display("FAIL reset_rx_dout: got %h expected 00", rx_dout); end
    checks++; if (rx_avail !== 1'b0)   begin errors++; $display("FAIL reset_rx_avail: got %b expected 0", rx_avail); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", tx_underrun); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tx_empty !== 1'b1 || tx_full !== 1'b0) begin errors++; $display("FAIL reset_fifo: got empty=%b full=%b expected empty=1 full=0", tx_empty, tx_full); end
    Rst = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] mi, exp;
    urun_cycles = 0;
    push(8'hA5);
    checks++; if (tx_empty !== 1'b0) begin errors++; $display("FAIL basic_not_empty: got %b expected 0", tx_empty); end
    select();
    repeat (4) @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    xfer(8'h3C, 1'b1, 1'b0, mi);
    exp = next_miso();
    checks++; if (mi !== exp) begin errors++; $display("FAIL basic_miso: got %h expected %h", mi, exp); end
    wait_avail();
    exp = exp_rx.pop_front();
    checks++; if (rx_avail !== 1'b1) begin errors++; $display("FAIL basic_rx_avail: got %b expected 1", rx_avail); end
    checks++; if (rx_dout !== exp)   begin errors++; $display("FAIL basic_rx_dout: got %h expected %h", rx_dout, exp); end
    repeat (5) @(posedge clk); #1;
    checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after: got %b expected 1", tx_empty); end
    checks++; if (urun_cycles != 0)  begin errors++; $display("FAIL basic_no_underrun: got %0d expected 0", urun_cycles); end
    rx_rd = 1'b1; @(posedge clk); #1; rx_rd = 1'b0;
    checks++; if (rx_avail !== 1'b0) begin errors++; $display("FAIL basic_rd_clear: got %b expected 0", rx_avail); end
  endtask

  task automatic test_underrun();
    logic [7:0] mi, exp;
    urun_cycles = 0;
    select();
    xfer(8'h5A, 1'b1, 1'b0, mi);
    exp = next_miso();
    checks++; if (mi !== exp) begin errors++; $display("FAIL underrun_miso: got %h expected %h", mi, exp); end
    repeat (5) @(posedge clk); #1;
    checks++; if (urun_cycles != 1) begin errors++; $display("FAIL underrun_pulse: got %0d cycles expected 1", urun_cycles); end
    void'(exp_rx.pop_front());
    rx_rd = 1'b1; @(posedge clk); #1; rx_rd = 1'b0;
  endtask

  task automatic test_fifo_burst();
    logic [7:0] mi, exp, last_rx;
    logic [7:0] mos [4];
    mos = '{8'h11, 8'h22, 8'h33, 8'h44};
    urun_cycles = 0;
    for (int i = 1; i <= 4; i++) push(i[7:0]);
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL burst_full: got %b expected 1", tx_full); end
    push(8'h05);
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL burst_full_after_extra: got %b expected 1", tx_full); end
    select();
    for (int b = 0; b < 4; b++) begin
      xfer(mos[b], b == 3, 1'b0, mi);
      exp = next_miso();
      checks++; if (mi !== exp) begin errors++; $display("FAIL burst_miso%0d: got %h expected %h", b, mi, exp); end
    end
    wait_avail();
    last_rx = 8'h00;
    while (exp_rx.size() > 0) last_rx = exp_rx.pop_front();
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL burst_overrun: got %b expected 1", rx_overrun); end
    checks++; if (rx_dout !== last_rx) begin errors++; $display("FAIL burst_rx_dout: got %h expected %h", rx_dout, last_rx); end
    checks++; if (tx_empty !== 1'b1)   begin errors++; $display("FAIL burst_empty: got %b expected 1", tx_empty); end
    checks++; if (urun_cycles != 0)    begin errors++; $display("FAIL burst_no_underrun: got %0d expected 0", urun_cycles); end
    rx_rd = 1'b1; @(posedge clk); #1; rx_rd = 1'b0;
    checks++; if (rx_overrun !== 1'b0 || rx_avail !== 1'b0) begin errors++; $display("FAIL burst_rd_clear: got ovr=%b avail=%b expected 0 0", rx_overrun, rx_avail); end
  endtask

  task automatic test_partial();
    logic [7:0] mi, exp;
    select();
    sck_bits(8'hFF, 5);
    spi_cs = 1'b1;
    repeat (10) @(posedge clk); #1;
    checks++; if (rx_avail !== 1'b0) begin errors++; $display("FAIL partial_no_avail: got %b expected 0", rx_avail); end
    select();
    xfer(8'h96, 1'b1, 1'b0, mi);
    exp = next_miso();
    checks++; if (mi !== exp) begin errors++; $display("FAIL partial_next_miso: got %h expected %h", mi, exp); end
    wait_avail();
    exp = exp_rx.pop_front();
    checks++; if (rx_dout !== exp || rx_avail !== 1'b1) begin errors++; $display("FAIL partial_next_rx: got %h/%b expected %h/1", rx_dout, rx_avail, exp); end
  endtask

  task automatic test_rd_at_completion();
    logic [7:0] mi, exp;
    // rx_avail is still set from the previous transfer.
    select();
    xfer(8'hC6, 1'b1, 1'b1, mi);
    void'(next_miso());
    wait_avail();
    exp = exp_rx.pop_front();
    checks++; if (rx_avail !== 1'b1)   begin errors++; $display("FAIL rdcomp_avail: got %b expected 1", rx_avail); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rdcomp_overrun: got %b expected 0", rx_overrun); end
    checks++; if (rx_dout !== exp)     begin errors++; $display("FAIL rdcomp_rx_dout: got %h expected %h", rx_dout, exp); end
    rx_rd = 1'b1; @(posedge clk); #1; rx_rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi, exp;
    push(8'hC3);
    select();
    sck_bits(8'h81, 3);
    spi_sck = 1'b1;
    repeat (2) @(posedge clk);
    #3 Rst = 1'b0;
    #1;
    checks++; if (spi_miso !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_pins: got miso=%b busy=%b expected 1 0", spi_miso, busy); end
    checks++; if (tx_empty !== 1'b1 || tx_full !== 1'b0) begin errors++; $display("FAIL rstmid_fifo: got empty=%b full=%b expected 1 0", tx_empty, tx_full); end
    checks++; if (rx_avail !== 1'b0 || rx_overrun !== 1'b0 || rx_dout !== 8'h00 || tx_underrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_rx: got avail=%b ovr=%b dout=%h urun=%b expected 0 0 00 0", rx_avail, rx_overrun, rx_dout, tx_underrun);
    end
    spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    exp_miso.delete();
    exp_rx.delete();
    repeat (3) @(posedge clk); #1;
    Rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    push(8'h7E);
    select();
    xfer(8'hE7, 1'b1, 1'b0, mi);
    exp = next_miso();
    checks++; if (mi !== exp) begin errors++; $display("FAIL rstmid_after_miso: got %h expected %h", mi, exp); end
    wait_avail();
    exp = exp_rx.pop_front();
    checks++; if (rx_dout !== exp || rx_avail !== 1'b1) begin errors++; $display("FAIL rstmid_after_rx: got %h/%b expected %h/1", rx_dout, rx_avail, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_fifo_burst();
    test_partial();
    test_rd_at_completion();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI mode-0 target (peripheral) that answers the SoC's SPI master controller on the `spi_sck/spi_cs/spi_mosi/spi_miso` pins. It oversamples the SPI pins with the system clock, deserializes MOSI bytes into a receive holding register, and serializes MISO bytes from a small transmit FIFO. It is used as the board-side loopback/target for SPI bring-up and as the device model in system simulation.

## Interface
- `TX_DEPTH`, 4: transmit FIFO depth in bytes; must be a power of two and at least 2.
- `IDLE_BYTE`, 8'hFF: byte shifted out when the FIFO is empty at load time.
- `clk` in 1: system clock; all logic is on its rising edge.
- `Rst` in 1: asynchronous, active-low reset (0 = reset).
- `spi_sck` in 1: SPI clock from master, asynchronous to `clk`.
- `spi_cs` in 1: chip select from master, active low, asynchronous.
- `spi_mosi` in 1: serial data from master, asynchronous.
- `spi_miso` out 1: serial data to master.
- `tx_din` in 8: byte to queue for transmission.
- `tx_wr` in 1: push `tx_din` into the FIFO (one byte per cycle).
- `tx_full` out 1: FIFO holds `TX_DEPTH` bytes.
- `tx_empty` out 1: FIFO holds 0 bytes.
- `rx_dout` out 8: last complete received byte.
- `rx_avail` out 1: `rx_dout` holds an unread byte.
- `rx_rd` in 1: acknowledge/consume `rx_dout`.
- `rx_overrun` out 1: sticky; a byte completed while `rx_avail` was 1. Cleared by `rx_rd`.
- `tx_underrun` out 1: one-cycle pulse when `IDLE_BYTE` is loaded because the FIFO was empty.
- `busy` out 1: synchronized CS is asserted.

## Operation
- Pin synchronizers: two flops on each of `spi_sck`, `spi_cs`, `spi_mosi`. A third flop on SCK and CS provides edge detection.
- FSM states: `S_IDLE`, `S_LOAD`, `S_SHIFT`.
  - `S_IDLE`: `spi_miso`=1, `bit_cnt`=0. A synchronized CS falling edge moves to `S_LOAD`.
  - `S_LOAD`, one cycle: `tx_shift` is loaded with the FIFO head and the FIFO pops. If the FIFO is empty, `tx_shift` gets `IDLE_BYTE` and `tx_underrun` pulses. The FSM then moves to `S_SHIFT`.
  - `S_SHIFT`: `spi_miso` = `tx_shift[7]`.
    - SCK rising edge: `rx_shift` <= {`rx_shift[6:0]`, mosi}; `bit_cnt` increments modulo 8.
    - When `bit_cnt` wraps from 7 to 0: `rx_dout` <= the completed byte and `rx_avail` <= 1. If `rx_avail` was already 1 and `rx_rd` is 0, `rx_overrun` <= 1.
    - SCK falling edge with `bit_cnt`≠0: `tx_shift` shifts left by 1.
    - SCK falling edge with `bit_cnt`=0 (byte boundary): go to `S_LOAD` for the next byte.
  - From any state, a synchronized CS rising edge goes to `S_IDLE`. Partial RX bits are discarded, with no `rx_avail`. A loaded but unsent TX byte is discarded; it is not returned to the FIFO.
- Byte order is MSB first on both lines.
- FIFO counters are `$clog2(TX_DEPTH)+1` bits with wrapping read/write pointers.
  - A `tx_wr` while full is ignored.
  - A push and a pop in the same cycle when full: the pop occurs and the write is accepted.
- Simultaneous `rx_rd` and byte completion: the new byte is loaded, `rx_avail` stays 1, and no overrun is flagged.
- Reset values: `spi_miso`=1, `rx_dout`=0, `rx_avail`=0, `rx_overrun`=0, `tx_underrun`=0, `busy`=0, `tx_empty`=1, `tx_full`=0, FSM in `S_IDLE`, FIFO empty. Reset mid-transfer abandons the transfer with no further outputs.

## Timing
- Pin-to-action latency: a pin edge is acted on 3 `clk` cycles after it arrives (two sync stages plus the edge register).
- `spi_miso` is valid at most 4 cycles after the CS falling edge or an SCK falling edge.
- Master constraints: SCK high and low times must each be ≥ 5 `clk` cycles, and the CS-fall-to-first-SCK-rise time must be ≥ 5 cycles. At `clk`=50 MHz this caps SCK at 5 MHz.
- `rx_avail` rises 3 cycles after the 8th SCK rising edge.
- Register/FIFO timing:
  - `tx_full`/`tx_empty` update on the cycle after `tx_wr` or a pop.
  - `rx_avail` clears on the cycle after `rx_rd`.

## Structure
- Shared package `spi_pkg`: `spi_state_t` enum {`S_IDLE`, `S_LOAD`, `S_SHIFT`} and `SPI_IDLE_BYTE` = 8'hFF. The SPI master controller shares the same constant.
- Sub-module `spi_tx_fifo`: synchronous FIFO parameterized by depth, with push/pop/full/empty outputs. The FSM, synchronizers and shift registers stay in `spi_responder`.

## Test plan
- Push 8'hA5 then CS low and 8 SCK cycles with MOSI=8'h3C → MISO bits 1,0,1,0,0,1,0,1; `rx_dout`=8'h3C, `rx_avail`=1; `tx_empty`=1 afterwards.
- Empty FIFO, one 8-bit transfer → MISO=8'hFF, `tx_underrun` pulses once for exactly 1 cycle.
- Push 8'h01, 8'h02, 8'h03, 8'h04 (5th push ignored, `tx_full`=1), then a 4-byte burst → MISO 01,02,03,04; `rx_overrun`=1 when `rx_rd` is never asserted, and `rx_dout` = the 4th MOSI byte.
- CS deasserted after 5 SCK edges → `rx_avail` stays 0; the next full transfer receives its byte correctly from bit 7.
- `rx_rd` asserted in the same cycle as byte completion → `rx_avail`=1 and `rx_overrun`=0.
- `Rst` driven to 0 mid-byte → all outputs return to their reset values immediately, with no clock required; after release, a normal transfer succeeds.
